// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - modulo up/down counter with load, wrap/saturate and ovf pulse
// Optional prescaler enabled by defining CNT_PRESCALE_EN.
module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int MODE     = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam bit SATURATE = (MODE == 1);

    // Elaboration-time guards on the parameter ranges the counter relies on
    if (WIDTH < 2) begin : g_bad_width
        $error("counter_updown_mod: WIDTH must be >= 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
        $error("counter_updown_mod: MAX_VAL out of range");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("counter_updown_mod: MODE must be 0 or 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_updown_mod: PRESCALE must be >= 1");
    end

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clip;
    logic [WIDTH-1:0] step_cnt;
    logic             step_ovf;

    assign at_max    = (cnt == MAX_V);
    assign at_zero   = (cnt == '0);
    assign at_limit  = (up_down && at_max) || (!up_down && at_zero);
    assign load_clip = (load_val > MAX_V) ? MAX_V : load_val;

    // Next value for a qualified step; limits are detected by compare, not by rollover
    always_comb begin
        step_cnt = cnt;
        step_ovf = 1'b0;
        if (up_down) begin
            if (at_max) begin
                step_ovf = 1'b1;
                step_cnt = SATURATE ? cnt : '0;
            end else begin
                step_cnt = cnt + 1'b1;
            end
        end else begin
            if (at_zero) begin
                step_ovf = 1'b1;
                step_cnt = SATURATE ? cnt : MAX_V;
            end else begin
                step_cnt = cnt - 1'b1;
            end
        end
    end

`ifdef CNT_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
            ps  <= '0;
        end else if (load) begin
            cnt <= load_clip;
            ovf <= 1'b0;
            ps  <= '0;
        end else if (en) begin
            if (ps == PS_LAST) begin
                ps  <= '0;
                cnt <= step_cnt;
                ovf <= step_ovf;
            end else begin
                ps  <= ps + 1'b1;
                ovf <= 1'b0;
            end
        end else begin
            ovf <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            cnt <= load_clip;
            ovf <= 1'b0;
        end else if (en) begin
            cnt <= step_cnt;
            ovf <= step_ovf;
        end else begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule
